// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encodings and frame constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
    TX_PARITY_BIT = 3'd3,
    TX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } uart_state_e;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;

  function automatic int unsigned frame_bits(
    input bit parity_en
  );
    return START_BITS + DATA_BITS + STOP_BITS
         + (parity_en ? 32'd1 : 32'd0);
  endfunction

  function automatic logic parity_of(
    input logic [7:0] d,
    input logic       odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer, first-word-fall-through.
// Pointers carry an extra MSB to tell full from empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q;
  logic [AW:0]      wptr_d;
  logic [AW:0]      rptr_q;
  logic [AW:0]      rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign full  = (wptr_q[AW] != rptr_q[AW])
              && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  // writes while full are dropped; reads while empty ignored
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign rd_data = mem_q[rptr_q[AW-1:0]];

  // next pointer values
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + PTR_ONE;
    if (do_rd) rptr_d = rptr_q + PTR_ONE;
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // storage array, contents qualified by the pointers
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes out as start/data/parity/stop.
// All line outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic P_EN  = (PARITY_EN != 0);
  localparam logic P_ODD = (PARITY_ODD != 0);

  uart_state_e state_q;
  uart_state_e state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          ser_q;
  logic          ser_d;
  logic          act_q;
  logic          act_d;
  logic          done_q;
  logic          done_d;
  logic          avail_q;

  logic          pop;
  logic          bit_end;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Rst_L),
    .wr_en   (i_TX_DV),
    .wr_data (i_TX_Byte),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_TX_Ready  = ~fifo_full;
  assign o_TX_Active = act_q;
  assign o_TX_Serial = ser_q;
  assign o_TX_Done   = done_q;

  assign bit_end = (cnt_q == CNT_MAX);

  // one-cycle handoff stage: a byte written into an
  // empty buffer is seen by IDLE one edge later
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) avail_q <= 1'b0;
    else          avail_q <= ~fifo_empty;
  end

  // next-state, line level and buffer pop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ser_d   = ser_q;
    act_d   = act_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        act_d = 1'b0;
        cnt_d = '0;
        idx_d = '0;
        if (avail_q && !fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          ser_d   = 1'b0;
          act_d   = 1'b1;
          state_d = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          ser_d   = data_q[0];
          state_d = TX_DATA_BITS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_DATA_BITS: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            if (P_EN) begin
              ser_d   = parity_of(data_q, P_ODD);
              state_d = TX_PARITY_BIT;
            end else begin
              ser_d   = 1'b1;
              state_d = TX_STOP_BIT;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            ser_d = data_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_PARITY_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          ser_d   = 1'b1;
          state_d = TX_STOP_BIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_STOP_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          ser_d   = 1'b1;
          act_d   = 1'b0;
          done_d  = 1'b1;
          state_d = CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CLEANUP: begin
        ser_d   = 1'b1;
        act_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        ser_d   = 1'b1;
        act_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

endmodule
